// File: rtl/tm1638_spi_burst.sv
// Purpose: strobe-framed TM1638 serial engine: command byte, then a write burst or a key-scan read burst.
// Latency: busy for 2 + bit cells + GAP cycles (read adds TWAIT bit periods); o_Done pulses in the final busy cycle.
// Backpressure: i_Start is only accepted in IDLE; requests while busy are dropped (flagged on o_Overrun with SPI_OVERRUN_EN).
module tm1638_spi_burst #(
   parameter int CYCLES    = 1,
   parameter int MAX_BYTES = 16,
   parameter int RD_BYTES  = 4,
   parameter int TWAIT     = 2,
   parameter int GAP       = 2,
   localparam int LW       = $clog2(MAX_BYTES + 1)
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst_n,
   input  logic                   i_Start,
   input  logic                   i_Read,
   input  logic [7:0]             i_Cmd,
   input  logic [LW-1:0]          i_Len,
   input  logic [8*MAX_BYTES-1:0] i_Data,
   output logic                   o_Busy,
   output logic                   o_Done,
   output logic [31:0]            o_Rd_Data,
   output logic                   o_Rd_Valid,
   output logic                   o_SPI_Stb,
   output logic                   o_SPI_Clk,
   output logic                   o_SPI_Dio,
   output logic                   o_SPI_Dio_Oe,
`ifdef SPI_OVERRUN_EN
   output logic                   o_Overrun,
`endif
   input  logic                   i_SPI_Dio
);

   // One counter serves the bit cell, the turnaround wait and the strobe gap,
   // so it is sized for the longest of the three.
   localparam int HALF  = CYCLES + 1;
   localparam int BITP  = 2 * HALF;
   localparam int WAITC = TWAIT * BITP;
   localparam int MAXA  = (WAITC > BITP) ? WAITC : BITP;
   localparam int MAXC  = (GAP > MAXA) ? GAP : MAXA;
   localparam int CW    = $clog2(MAXC);
   // Byte counter must hold both the write length and RD_BYTES (up to 4).
   localparam int BW    = (LW > 3) ? LW : 3;
   localparam int RD_SHIFT = 32 - 8 * RD_BYTES;

   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
   localparam logic [CW-1:0] BITP_M1 = CW'(BITP - 1);
   localparam logic [CW-1:0] WAIT_M1 = CW'((WAITC > 0) ? WAITC - 1 : 0);
   localparam logic [CW-1:0] GAP_M1  = CW'(GAP - 1);
   localparam logic [LW-1:0] MAX_LEN = LW'(MAX_BYTES);
   localparam logic [BW-1:0] RD_LEN  = BW'(RD_BYTES);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_CMD, S_WAIT, S_WDATA, S_RDATA, S_GAP, S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [2:0]             bit_q, bit_d;
   logic [BW-1:0]          byte_q, byte_d;
   logic                   read_q, read_d;
   logic [7:0]             cmd_q, cmd_d;
   logic [LW-1:0]          len_q, len_d;
   logic [8*MAX_BYTES-1:0] data_q, data_d;
   logic [31:0]            rd_sh_q, rd_sh_d;
   logic [31:0]            rd_data_q, rd_data_d;

   logic                   bit_end;
   logic [BW-1:0]          byte_nxt;
   logic [LW-1:0]          len_clamp;
   logic [7:0]             cur_byte;

   // Write payload is consumed by shifting, so the byte on the wire is always the low byte.
   assign cur_byte  = data_q[7:0];
   assign len_clamp = (i_Len > MAX_LEN) ? MAX_LEN : i_Len;
   assign o_Rd_Data = rd_data_q;

   // State register.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Datapath registers: counters, latched request and read shifter.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         cnt_q     <= '0;
         bit_q     <= '0;
         byte_q    <= '0;
         read_q    <= 1'b0;
         cmd_q     <= '0;
         len_q     <= '0;
         data_q    <= '0;
         rd_sh_q   <= '0;
         rd_data_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         byte_q    <= byte_d;
         read_q    <= read_d;
         cmd_q     <= cmd_d;
         len_q     <= len_d;
         data_q    <= data_d;
         rd_sh_q   <= rd_sh_d;
         rd_data_q <= rd_data_d;
      end
   end

   // Next-state, counter sequencing and pin outputs.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      byte_d    = byte_q;
      read_d    = read_q;
      cmd_d     = cmd_q;
      len_d     = len_q;
      data_d    = data_q;
      rd_sh_d   = rd_sh_q;
      rd_data_d = rd_data_q;
      bit_end   = (cnt_q == BITP_M1);
      byte_nxt  = byte_q + BW'(1);

      o_Busy       = (state_q != S_IDLE);
      o_Done       = (state_q == S_DONE);
      o_Rd_Valid   = (state_q == S_DONE) && read_q;
      o_SPI_Stb    = 1'b1;
      o_SPI_Clk    = 1'b1;
      o_SPI_Dio    = 1'b0;
      o_SPI_Dio_Oe = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_Start) begin
               state_d = S_LOAD;
               read_d  = i_Read;
               cmd_d   = i_Cmd;
               len_d   = len_clamp;
               data_d  = i_Data;
            end
         end
         S_LOAD: begin
            state_d = S_CMD;
            cnt_d   = '0;
            bit_d   = '0;
            byte_d  = '0;
         end
         S_CMD: begin
            o_SPI_Stb    = 1'b0;
            o_SPI_Dio_Oe = 1'b1;
            o_SPI_Clk    = (cnt_q > HALF_M1);
            o_SPI_Dio    = cmd_q[bit_q];
            cnt_d        = bit_end ? '0 : cnt_q + CW'(1);
            if (bit_end) begin
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  if (read_q)            state_d = (TWAIT > 0) ? S_WAIT : S_RDATA;
                  else if (len_q != '0)  state_d = S_WDATA;
                  else                   state_d = S_GAP;
               end
            end
         end
         S_WAIT: begin
            // Clock parked high with DIO released so the chip can take the line.
            o_SPI_Stb = 1'b0;
            if (cnt_q == WAIT_M1) begin
               cnt_d   = '0;
               state_d = S_RDATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WDATA: begin
            o_SPI_Stb    = 1'b0;
            o_SPI_Dio_Oe = 1'b1;
            o_SPI_Clk    = (cnt_q > HALF_M1);
            o_SPI_Dio    = cur_byte[bit_q];
            cnt_d        = bit_end ? '0 : cnt_q + CW'(1);
            if (bit_end) begin
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  data_d = data_q >> 8;
                  byte_d = byte_nxt;
                  if (byte_nxt == BW'(len_q)) state_d = S_GAP;
               end
            end
         end
         S_RDATA: begin
            o_SPI_Stb = 1'b0;
            o_SPI_Clk = (cnt_q > HALF_M1);
            cnt_d     = bit_end ? '0 : cnt_q + CW'(1);
            if (bit_end) begin
               // Last high cycle before the falling edge: the chip's bit is settled.
               rd_sh_d = {i_SPI_Dio, rd_sh_q[31:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  byte_d = byte_nxt;
                  if (byte_nxt == RD_LEN) state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_M1) begin
               cnt_d   = '0;
               state_d = S_DONE;
               // Shifter fills from the top; align so unread bytes come out as zero.
               if (read_q) rd_data_d = rd_sh_q >> RD_SHIFT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

`ifdef SPI_OVERRUN_EN
   logic ovr_q, ovr_d;

   // Sticky flag for requests dropped while busy; an accepted 0xFF command clears it.
   always_comb begin
      ovr_d = ovr_q;
      if (state_q == S_IDLE && i_Start && i_Cmd == 8'hFF)
         ovr_d = 1'b0;
      else if (i_Start && state_q != S_IDLE && state_q != S_DONE)
         ovr_d = 1'b1;
   end

   // Overrun flag register.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) ovr_q <= 1'b0;
      else          ovr_q <= ovr_d;
   end

   assign o_Overrun = ovr_q;
`endif

endmodule

// File: tb/tb_tm1638_spi_burst.sv
// Purpose: scoreboard bench for tm1638_spi_burst with a TM1638 key-scan device model.
// Latency: expectations are queued at request time and checked when o_Done pulses.
// Backpressure: requests are issued only when the DUT is idle, except the deliberate held/overrun cases.
module tb_tm1638_spi_burst;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_Start, i_Read;
   logic [7:0]   i_Cmd;
   logic [4:0]   i_Len;
   logic [127:0] i_Data;
   logic         o_Busy, o_Done, o_Rd_Valid;
   logic [31:0]  o_Rd_Data;
   logic         o_SPI_Stb, o_SPI_Clk, o_SPI_Dio, o_SPI_Dio_Oe;
   logic         spi_dio_in;
`ifdef SPI_OVERRUN_EN
   logic         o_Overrun;
`endif

   tm1638_spi_burst dut (
      .i_Clk        (clk),
      .i_Rst_n      (rst_n),
      .i_Start      (i_Start),
      .i_Read       (i_Read),
      .i_Cmd        (i_Cmd),
      .i_Len        (i_Len),
      .i_Data       (i_Data),
      .o_Busy       (o_Busy),
      .o_Done       (o_Done),
      .o_Rd_Data    (o_Rd_Data),
      .o_Rd_Valid   (o_Rd_Valid),
      .o_SPI_Stb    (o_SPI_Stb),
      .o_SPI_Clk    (o_SPI_Clk),
      .o_SPI_Dio    (o_SPI_Dio),
      .o_SPI_Dio_Oe (o_SPI_Dio_Oe),
`ifdef SPI_OVERRUN_EN
      .o_Overrun    (o_Overrun),
`endif
      .i_SPI_Dio    (spi_dio_in)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0]  busy;
      logic [31:0]  stb;
      logic [31:0]  pulses;
      logic [31:0]  oe;
      logic [31:0]  run;
      logic [31:0]  nbits;
      logic [135:0] tx;
      logic [31:0]  rd_data;
      logic         rd_vld;
   } exp_t;

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] last_rd = '0;
   logic [31:0] rd_pat = 32'hA5003C81;

   // Per-transaction observations, cleared whenever the DUT is idle.
   int           m_busy, m_stb, m_oe, m_run, m_maxrun, m_pulses;
   logic [7:0]   m_capn;
   logic [5:0]   m_rdn;
   logic [135:0] m_cap;
   logic         prev_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
      end
   endtask

   task automatic chk_tx(input logic [135:0] act, input logic [135:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL tx_bits: got %0h, expected %0h", act, exp_v);
      end
   endtask

   // Queue the expected result. busy/pulses are hand-computed per vector;
   // strobe-low time is busy minus LOAD, DONE and the 2-cycle gap.
   task automatic push_exp(input logic rd, input logic [7:0] cmd, input logic [4:0] len,
                           input logic [127:0] data, input int busy, input int pulses,
                           input logic [31:0] rdexp);
      exp_t e;
      int   l;
      l = rd ? 0 : ((len > 5'd16) ? 16 : int'(len));
      e.busy    = busy;
      e.stb     = busy - 4;
      e.pulses  = pulses;
      e.oe      = rd ? 32 : busy - 4;        // read: only the 8 command bit cells drive DIO
      e.run     = rd ? 10 : 2;               // read: last CMD high phase (2) + WAIT (8)
      e.nbits   = 8 * (l + 1);
      e.tx      = '0;
      e.tx[7:0] = cmd;
      for (int k = 0; k < l; k++) e.tx[8*(k+1) +: 8] = data[8*k +: 8];
      e.rd_data = rd ? rdexp : last_rd;
      e.rd_vld  = rd;
      if (rd) last_rd = rdexp;
      q.push_back(e);
   endtask

   task automatic drive(input logic rd, input logic [7:0] cmd, input logic [4:0] len,
                        input logic [127:0] data);
      @(negedge clk);
      i_Read  = rd;
      i_Cmd   = cmd;
      i_Len   = len;
      i_Data  = data;
      i_Start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_Start = 1'b0;
   endtask

   task automatic send(input logic rd, input logic [7:0] cmd, input logic [4:0] len,
                       input logic [127:0] data, input int busy, input int pulses,
                       input logic [31:0] rdexp);
      push_exp(rd, cmd, len, data, busy, pulses, rdexp);
      drive(rd, cmd, len, data);
   endtask

   task automatic wait_idle(input string tag);
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while ((q.size() != 0 || o_Busy) && t < 3000);
      if (t >= 3000) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout_%s: still busy after %0d cycles, expected idle", tag, t);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n   = 1'b0;
      i_Start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n   = 1'b1;
      last_rd = '0;
   endtask

   // Monitor + device model: observes pins every cycle, drives read data on
   // SPI falling edges while DIO is released, and scores each o_Done.
   initial begin
      exp_t e;
      m_busy = 0; m_stb = 0; m_oe = 0; m_run = 0; m_maxrun = 0; m_pulses = 0;
      m_capn = '0; m_rdn = '0; m_cap = '0; prev_clk = 1'b1; spi_dio_in = 1'b0;
      forever begin
         @(negedge clk);
         if (o_Busy) begin
            m_busy++;
            if (!o_SPI_Stb) m_stb++;
            if (o_SPI_Dio_Oe) m_oe++;
            if (!o_SPI_Stb && o_SPI_Clk) begin
               m_run++;
               if (m_run > m_maxrun) m_maxrun = m_run;
            end else begin
               m_run = 0;
            end
            if (!prev_clk && o_SPI_Clk) begin
               m_pulses++;
               if (o_SPI_Dio_Oe && m_capn < 8'd136) begin
                  m_cap[m_capn] = o_SPI_Dio;
                  m_capn++;
               end
            end
            if (prev_clk && !o_SPI_Clk && !o_SPI_Dio_Oe && !o_SPI_Stb) begin
               spi_dio_in = (m_rdn < 6'd32) ? rd_pat[m_rdn[4:0]] : 1'b0;
               m_rdn++;
            end
            if (o_Done) begin
               if (q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_done: got o_Done=1, expected no completion");
               end else begin
                  e = q.pop_front();
                  chk("busy_cycles", m_busy, e.busy);
                  chk("stb_low_cycles", m_stb, e.stb);
                  chk("clk_pulses", m_pulses, e.pulses);
                  chk("oe_cycles", m_oe, e.oe);
                  chk("max_clk_high_run", m_maxrun, e.run);
                  chk("tx_bit_count", {24'b0, m_capn}, e.nbits);
                  chk_tx(m_cap, e.tx);
                  chk("rd_valid", {31'b0, o_Rd_Valid}, {31'b0, e.rd_vld});
                  chk("rd_data", o_Rd_Data, e.rd_data);
               end
            end
         end else begin
            if (o_Done) begin
               n_cmp++;
               n_bad++;
               $display("FAIL done_while_idle: got o_Done=1, expected 0");
            end
            m_busy = 0; m_stb = 0; m_oe = 0; m_run = 0; m_maxrun = 0; m_pulses = 0;
            m_capn = '0; m_rdn = '0; m_cap = '0;
         end
         if (o_Rd_Valid && !o_Done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rd_valid_alone: got o_Rd_Valid=1 without o_Done");
         end
         prev_clk = o_SPI_Clk;
      end
   end

   // Directed stimulus.
   initial begin
      logic [127:0] d_k, d_r;
      int           t;
      rst_n = 1'b0; i_Start = 1'b0; i_Read = 1'b0; i_Cmd = '0; i_Len = '0; i_Data = '0;
      for (int k = 0; k < 16; k++) d_k[8*k +: 8] = 8'(k);
      d_r = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'b0, o_Busy}, 32'd0);
      chk("rst_done", {31'b0, o_Done}, 32'd0);
      chk("rst_rd_valid", {31'b0, o_Rd_Valid}, 32'd0);
      chk("rst_rd_data", o_Rd_Data, 32'd0);
      chk("rst_stb", {31'b0, o_SPI_Stb}, 32'd1);
      chk("rst_clk", {31'b0, o_SPI_Clk}, 32'd1);
      chk("rst_dio", {31'b0, o_SPI_Dio}, 32'd0);
      chk("rst_oe", {31'b0, o_SPI_Dio_Oe}, 32'd0);
`ifdef SPI_OVERRUN_EN
      chk("rst_overrun", {31'b0, o_Overrun}, 32'd0);
`endif
      rst_n = 1'b1;

      // Command only: 2 + 32 + 2 = 36 busy cycles.
      send(1'b0, 8'h40, 5'd0, '0, 36, 8, '0);
      wait_idle("w0");
      // Full 16-byte burst: 2 + 136*4 + 2 = 548.
      send(1'b0, 8'hC0, 5'd16, d_k, 548, 136, '0);
      wait_idle("w16");
      // Read 4 bytes: 2 + (8 + 32 + 2)*4 + 2 = 172.
      send(1'b1, 8'h42, 5'd0, '0, 172, 40, 32'hA5003C81);
      wait_idle("rd");
      // Length 31 clamps to 16; read data must hold across a write.
      send(1'b0, 8'h44, 5'd31, d_r, 548, 136, '0);
      wait_idle("clamp");

      // Reset in data byte 3 of a write: abort, no completion.
      drive(1'b0, 8'hC0, 5'd8, d_k);
      t = 0;
      while (m_pulses < 36 && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("abort_reached_byte3", {31'b0, (t < 400)}, 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_stb", {31'b0, o_SPI_Stb}, 32'd1);
      chk("abort_clk", {31'b0, o_SPI_Clk}, 32'd1);
      chk("abort_oe", {31'b0, o_SPI_Dio_Oe}, 32'd0);
      chk("abort_busy", {31'b0, o_Busy}, 32'd0);
      chk("abort_done", {31'b0, o_Done}, 32'd0);
      chk("abort_rd_data", o_Rd_Data, 32'd0);
      rst_n   = 1'b1;
      last_rd = '0;
      repeat (3) @(negedge clk);
      // Next transaction bit-exact: 2 + 24*4 + 2 = 100.
      send(1'b0, 8'h40, 5'd2, 128'h3412, 100, 24, '0);
      wait_idle("post_abort");

      // Start held high: not taken in DONE, taken at the following IDLE edge.
      push_exp(1'b0, 8'h41, 5'd1, 128'hA5, 68, 16, '0);
      push_exp(1'b0, 8'h41, 5'd1, 128'hA5, 68, 16, '0);
      @(negedge clk);
      i_Read = 1'b0; i_Cmd = 8'h41; i_Len = 5'd1; i_Data = 128'hA5; i_Start = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!o_Done && t < 200);
      chk("b2b_first_done", {31'b0, o_Done}, 32'd1);
      @(negedge clk);
      chk("b2b_idle_gap", {31'b0, o_Busy}, 32'd0);
      @(negedge clk);
      chk("b2b_second_start", {31'b0, o_Busy}, 32'd1);
      i_Start = 1'b0;
      wait_idle("b2b");

`ifdef SPI_OVERRUN_EN
      apply_reset();
      chk("ovr_after_reset", {31'b0, o_Overrun}, 32'd0);
      send(1'b0, 8'h40, 5'd1, 128'h5A, 68, 16, '0);
      repeat (10) @(negedge clk);
      i_Start = 1'b1;
      i_Cmd   = 8'hFF;
      @(negedge clk);
      i_Start = 1'b0;
      chk("ovr_set", {31'b0, o_Overrun}, 32'd1);
      wait_idle("ovr_write");
      chk("ovr_sticky", {31'b0, o_Overrun}, 32'd1);
      send(1'b0, 8'hFF, 5'd0, '0, 36, 8, '0);
      chk("ovr_cleared", {31'b0, o_Overrun}, 32'd0);
      wait_idle("ovr_ff");
`endif

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
